id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that directly feeds the execute-stage ALU.
- Captures one decoded instruction and resolves operand forwarding from the EX/MEM and MEM/WB write-back buses.
- Detects load-use hazards and inserts a bubble.
- Presents registered A, B and ALUop to the ALU, with a valid/ready handshake on both sides plus flush.

Parameters:
- XLEN, 32, datapath width; must be 32 to match the ALU.
- RA_W, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts this cycle (combinational).
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  RA_W  source indices.
- in_rs1_used, in_rs2_used  in  1  source actually read.
- in_rs1_val, in_rs2_val  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_a_sel_pc  in  1  A := pc instead of rs1.
- in_b_sel_imm  in  1  B := imm instead of rs2.
- in_alu_op  in  4  ALU opcode, passed through unchanged.
- in_rd  in  RA_W  destination index.
- in_reg_write, in_mem_read, in_mem_write  in  1  control bits.
- flush  in  1  kill held entry and any same-cycle incoming transfer.
- exm_wen  in  1  EX/MEM bypass valid (value final, including load data).
- exm_rd  in  RA_W  EX/MEM bypass index.
- exm_val  in  XLEN  EX/MEM bypass data.
- wb_wen, wb_rd, wb_val  in  1/RA_W/XLEN  MEM/WB bypass (same meaning).
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  execute stage consumes this cycle.
- alu_a, alu_b  out  XLEN  ALU operands (registered).
- alu_op  out  4  ALU opcode (registered).
- out_store_data  out  XLEN  forwarded rs2 value, for stores.
- out_pc  out  XLEN  instruction PC.
- out_rd  out  RA_W  destination index.
- out_reg_write, out_mem_read, out_mem_write  out  1  control bits; forced 0 whenever out_valid=0.

Behaviour:
- **Reset:** while rst=1 on a clock edge, every output register becomes 0. out_valid=0, alu_op=4'b0000.
- **Forwarding value** for a source index s with register-file value v:
  - s==0 gives 0;
  - else exm_wen && exm_rd==s gives exm_val;
  - else wb_wen && wb_rd==s gives wb_val;
  - else v.
  - EX/MEM has priority over MEM/WB.
- **Load-use hazard:** lu = out_valid && out_mem_read && out_rd!=0 && ((in_rs1_used && in_rs1==out_rd) || (in_rs2_used && in_rs2==out_rd)).
- **Ready:** in_ready = flush || ((!out_valid || out_ready) && !lu).
- **Accept:** acc = in_valid && in_ready && !flush. On acc, at the next edge:
  - store the forwarded rs1/rs2 values;
  - alu_a = in_a_sel_pc ? in_pc : fwd rs1;
  - alu_b = in_b_sel_imm ? in_imm : fwd rs2;
  - out_store_data = fwd rs2;
  - copy alu_op, pc, rd and the control bits;
  - out_valid = 1.
- **Drain:** no acc, and out_valid && out_ready gives out_valid=0 and control bits 0 next cycle (bubble). Data fields keep their last values.
- **Hold:** out_valid && !out_ready && !flush means every field is held. Exception: each non-PC/non-imm operand, and out_store_data, is refreshed from a matching bypass (same priority, index!=0). This lets a value that lands late still reach the ALU.
- **Flush** has priority over acc, hold and drain. Next cycle out_valid=0 and all control bits are 0. A same-cycle incoming instruction is consumed and discarded (in_ready=1).
- **Load-use timing:**
  - cycle t: load held here, dependent blocked (in_ready=0).
  - At the edge where the load fires, the register empties (1-cycle bubble).
  - t+1: dependent accepted with forwarding from exm (load data).
  - Exactly one bubble per load-use pair.
- **Timing:**
  - Latency from accept to out_valid is 1 cycle.
  - Full throughput: accept and drain in the same cycle is allowed when out_ready=1 and lu=0.
  - Single entry; no skid buffer.
- **Mid-operation reset:** rst overrides flush and acc. in_ready is don't-care while rst=1.

Test Plan:
1. Reset, then in_valid with in_alu_op=4'b0010, rs1_val=5, b_sel_imm, imm=7 -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_op=4'b0010.
2. rs1=3 with exm_wen, exm_rd=3, exm_val=0xAA and simultaneously wb_rd=3, wb_val=0xBB -> alu_a=0xAA. With rs1=0 and exm_rd=0 -> alu_a=0.
3. Load with rd=4 held, next instruction uses rs2=4 -> in_ready=0. Load drains -> out_valid=0 for 1 cycle. Dependent accepted with exm_val=0x1234 -> alu_b=0x1234.
4. out_ready=0 for 3 cycles with wb_wen, wb_rd = held rs1 index, wb_val=0x55 in cycle 2 -> alu_a=0x55 from cycle 3. alu_op and out_pc unchanged throughout.
5. flush with in_valid=1 and a held entry -> next cycle out_valid=0, out_reg_write=0, out_mem_write=0. The incoming instruction never appears.
6. Back-to-back stream of 8 independent ops with out_ready=1 -> 8 consecutive out_valid cycles, no bubbles, opcodes in order.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every signal between decode, the ID/EX register, the execute stage
// and the two write-back bypass buses.
//   master : the surrounding pipeline (decode, bypass sources, execute stage)
//   slave  : the ID/EX stage itself
// Groups:
//   in_*   decoded instruction offered by decode, with in_valid/in_ready
//   flush  kills the held entry and any same-cycle transfer
//   exm_*  EX/MEM bypass (value is final, including load data)
//   wb_*   MEM/WB bypass
//   out_*, alu_*  registered operands/controls for execute, out_valid/out_ready
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [RA_W-1:0] in_rs1;
   logic [RA_W-1:0] in_rs2;
   logic            in_rs1_used;
   logic            in_rs2_used;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;
   logic [XLEN-1:0] in_imm;
   logic            in_a_sel_pc;
   logic            in_b_sel_imm;
   logic [3:0]      in_alu_op;
   logic [RA_W-1:0] in_rd;
   logic            in_reg_write;
   logic            in_mem_read;
   logic            in_mem_write;
   logic            flush;
   logic            exm_wen;
   logic [RA_W-1:0] exm_rd;
   logic [XLEN-1:0] exm_val;
   logic            wb_wen;
   logic [RA_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_val;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] out_store_data;
   logic [XLEN-1:0] out_pc;
   logic [RA_W-1:0] out_rd;
   logic            out_reg_write;
   logic            out_mem_read;
   logic            out_mem_write;

   modport master (
      output in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rs1_val, in_rs2_val, in_imm, in_a_sel_pc, in_b_sel_imm,
             in_alu_op, in_rd, in_reg_write, in_mem_read, in_mem_write,
             flush, exm_wen, exm_rd, exm_val, wb_wen, wb_rd, wb_val, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_op, out_store_data,
             out_pc, out_rd, out_reg_write, out_mem_read, out_mem_write
   );

   modport slave (
      input  in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rs1_val, in_rs2_val, in_imm, in_a_sel_pc, in_b_sel_imm,
             in_alu_op, in_rd, in_reg_write, in_mem_read, in_mem_write,
             flush, exm_wen, exm_rd, exm_val, wb_wen, wb_rd, wb_val, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_op, out_store_data,
             out_pc, out_rd, out_reg_write, out_mem_read, out_mem_write
   );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Single-entry ID/EX pipeline register feeding the execute-stage ALU.
// Resolves rs1/rs2 forwarding from the EX/MEM and MEM/WB buses, stalls decode
// for one cycle on a load-use dependency, and keeps refreshing held operands
// from the bypass buses while execute back-pressures.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous active-high reset, clears every output register
//   bus  - id_ex_stage_if.slave: decode input, flush, bypasses, ALU output
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input logic           clk,
   input logic           rst,
   id_ex_stage_if.slave  bus
);
   logic            valid_reg;
   logic [XLEN-1:0] alu_a_reg;
   logic [XLEN-1:0] alu_b_reg;
   logic [XLEN-1:0] store_data_reg;
   logic [XLEN-1:0] pc_reg;
   logic [3:0]      alu_op_reg;
   logic [RA_W-1:0] rd_reg;
   logic [RA_W-1:0] rs1_reg;
   logic [RA_W-1:0] rs2_reg;
   logic            a_sel_pc_reg;
   logic            b_sel_imm_reg;
   logic            reg_write_reg;
   logic            mem_read_reg;
   logic            mem_write_reg;

   // Incoming sources: [0]=rs1, [1]=rs2
   logic [RA_W-1:0] src_idx [2];
   logic [XLEN-1:0] src_val [2];
   logic [XLEN-1:0] fwd_val [2];

   // Held operands that can be refreshed: [0]=alu_a, [1]=alu_b, [2]=store data
   logic [RA_W-1:0] held_idx    [3];
   logic [XLEN-1:0] held_val    [3];
   logic            held_en     [3];
   logic [XLEN-1:0] refresh_next[3];

   logic lu;
   logic acc;

   assign src_idx[0] = bus.in_rs1;
   assign src_idx[1] = bus.in_rs2;
   assign src_val[0] = bus.in_rs1_val;
   assign src_val[1] = bus.in_rs2_val;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         // x0 always reads as zero; EX/MEM is younger than MEM/WB so it wins.
         assign fwd_val[gi] =
            (src_idx[gi] == '0)                              ? '0          :
            (bus.exm_wen && (bus.exm_rd == src_idx[gi]))    ? bus.exm_val :
            (bus.wb_wen  && (bus.wb_rd  == src_idx[gi]))    ? bus.wb_val  :
                                                              src_val[gi];
      end
   endgenerate

   assign held_idx[0] = rs1_reg;
   assign held_idx[1] = rs2_reg;
   assign held_idx[2] = rs2_reg;
   assign held_val[0] = alu_a_reg;
   assign held_val[1] = alu_b_reg;
   assign held_val[2] = store_data_reg;
   assign held_en[0]  = !a_sel_pc_reg;   // PC operand never refreshed
   assign held_en[1]  = !b_sel_imm_reg;  // immediate operand never refreshed
   assign held_en[2]  = 1'b1;            // store data always tracks rs2

   generate
      for (gi = 0; gi < 3; gi++) begin : g_refresh
         // While stalled, a producer that completes late still reaches the ALU.
         assign refresh_next[gi] =
            (!held_en[gi] || (held_idx[gi] == '0))            ? held_val[gi] :
            (bus.exm_wen && (bus.exm_rd == held_idx[gi]))    ? bus.exm_val  :
            (bus.wb_wen  && (bus.wb_rd  == held_idx[gi]))    ? bus.wb_val   :
                                                               held_val[gi];
      end
   endgenerate

   // A held load's data is not on any bypass yet, so its consumer must wait
   // until the load has moved into EX/MEM.
   assign lu = valid_reg && mem_read_reg && (rd_reg != '0) &&
               ((bus.in_rs1_used && (bus.in_rs1 == rd_reg)) ||
                (bus.in_rs2_used && (bus.in_rs2 == rd_reg)));

   assign bus.in_ready = bus.flush || ((!valid_reg || bus.out_ready) && !lu);
   assign acc          = bus.in_valid && bus.in_ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg      <= 1'b0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         store_data_reg <= '0;
         pc_reg         <= '0;
         alu_op_reg     <= 4'b0000;
         rd_reg         <= '0;
         rs1_reg        <= '0;
         rs2_reg        <= '0;
         a_sel_pc_reg   <= 1'b0;
         b_sel_imm_reg  <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
      end else if (bus.flush) begin
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
      end else if (acc) begin
         valid_reg      <= 1'b1;
         alu_a_reg      <= bus.in_a_sel_pc  ? bus.in_pc  : fwd_val[0];
         alu_b_reg      <= bus.in_b_sel_imm ? bus.in_imm : fwd_val[1];
         store_data_reg <= fwd_val[1];
         pc_reg         <= bus.in_pc;
         alu_op_reg     <= bus.in_alu_op;
         rd_reg         <= bus.in_rd;
         rs1_reg        <= bus.in_rs1;
         rs2_reg        <= bus.in_rs2;
         a_sel_pc_reg   <= bus.in_a_sel_pc;
         b_sel_imm_reg  <= bus.in_b_sel_imm;
         reg_write_reg  <= bus.in_reg_write;
         mem_read_reg   <= bus.in_mem_read;
         mem_write_reg  <= bus.in_mem_write;
      end else if (valid_reg && !bus.out_ready) begin
         alu_a_reg      <= refresh_next[0];
         alu_b_reg      <= refresh_next[1];
         store_data_reg <= refresh_next[2];
      end else if (valid_reg) begin
         // Consumed with nothing behind it: bubble, data fields keep values.
         valid_reg     <= 1'b0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
      end
   end

   assign bus.out_valid      = valid_reg;
   assign bus.alu_a          = alu_a_reg;
   assign bus.alu_b          = alu_b_reg;
   assign bus.alu_op         = alu_op_reg;
   assign bus.out_store_data = store_data_reg;
   assign bus.out_pc         = pc_reg;
   assign bus.out_rd         = rd_reg;
   assign bus.out_reg_write  = reg_write_reg & valid_reg;
   assign bus.out_mem_read   = mem_read_reg  & valid_reg;
   assign bus.out_mem_write  = mem_write_reg & valid_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed stimulus for id_ex_stage with a behavioural model of the stage
// contents and hand-computed literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

   id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [31:0] pc;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        asel;
      logic        bsel;
      logic        rw;
      logic        mr;
      logic        mw;
   } mstate_t;

   mstate_t m = '0;

   // Newest architectural value of register s as seen this cycle.
   function automatic logic [31:0] newest(input logic [4:0] s, input logic [31:0] v);
      if (s == 5'd0) return 32'd0;
      if (bus.exm_wen && bus.exm_rd == s) return bus.exm_val;
      if (bus.wb_wen && bus.wb_rd == s) return bus.wb_val;
      return v;
   endfunction

   function automatic logic model_ready();
      logic dep;
      dep = m.valid && m.mr && (m.rd != 5'd0) &&
            ((bus.in_rs1_used && bus.in_rs1 == m.rd) ||
             (bus.in_rs2_used && bus.in_rs2 == m.rd));
      return bus.flush || ((!m.valid || bus.out_ready) && !dep);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m = '0;
      end else if (bus.flush) begin
         m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      end else if (bus.in_valid && model_ready()) begin
         m.valid = 1'b1;
         m.a     = bus.in_a_sel_pc  ? bus.in_pc  : newest(bus.in_rs1, bus.in_rs1_val);
         m.b     = bus.in_b_sel_imm ? bus.in_imm : newest(bus.in_rs2, bus.in_rs2_val);
         m.sd    = newest(bus.in_rs2, bus.in_rs2_val);
         m.pc    = bus.in_pc;   m.op  = bus.in_alu_op; m.rd = bus.in_rd;
         m.rs1   = bus.in_rs1;  m.rs2 = bus.in_rs2;
         m.asel  = bus.in_a_sel_pc; m.bsel = bus.in_b_sel_imm;
         m.rw    = bus.in_reg_write; m.mr = bus.in_mem_read; m.mw = bus.in_mem_write;
      end else if (m.valid && !bus.out_ready) begin
         // x0 is already 0 in a held register-sourced operand, so newest() is exact.
         if (!m.asel) m.a = newest(m.rs1, m.a);
         if (!m.bsel) m.b = newest(m.rs2, m.b);
         m.sd = newest(m.rs2, m.sd);
      end else if (m.valid) begin
         m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready",      32'(bus.in_ready),      32'(model_ready()));
         chk("out_valid",     32'(bus.out_valid),     32'(m.valid));
         chk("out_reg_write", 32'(bus.out_reg_write), 32'(m.rw));
         chk("out_mem_read",  32'(bus.out_mem_read),  32'(m.mr));
         chk("out_mem_write", 32'(bus.out_mem_write), 32'(m.mw));
         if (m.valid) begin
            chk("alu_a",      bus.alu_a,              m.a);
            chk("alu_b",      bus.alu_b,              m.b);
            chk("alu_op",     32'(bus.alu_op),        32'(m.op));
            chk("store_data", bus.out_store_data,     m.sd);
            chk("out_pc",     bus.out_pc,             m.pc);
            chk("out_rd",     32'(bus.out_rd),        32'(m.rd));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
      bus.in_rs1_used = 0; bus.in_rs2_used = 0; bus.in_rs1_val = 0; bus.in_rs2_val = 0;
      bus.in_imm = 0; bus.in_a_sel_pc = 0; bus.in_b_sel_imm = 0; bus.in_alu_op = 0;
      bus.in_rd = 0; bus.in_reg_write = 0; bus.in_mem_read = 0; bus.in_mem_write = 0;
      bus.flush = 0; bus.exm_wen = 0; bus.exm_rd = 0; bus.exm_val = 0;
      bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_val = 0;
   endtask

   task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] rs1_val,
                        input logic [4:0] rs2, input logic [31:0] rs2_val, input logic [31:0] imm,
                        input logic bsel, input logic [3:0] op, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
      bus.in_valid = 1; bus.in_pc = pc;
      bus.in_rs1 = rs1; bus.in_rs1_used = (rs1 != 0); bus.in_rs1_val = rs1_val;
      bus.in_rs2 = rs2; bus.in_rs2_used = (rs2 != 0); bus.in_rs2_val = rs2_val;
      bus.in_imm = imm; bus.in_a_sel_pc = 0; bus.in_b_sel_imm = bsel; bus.in_alu_op = op;
      bus.in_rd = rd; bus.in_reg_write = rw; bus.in_mem_read = mr; bus.in_mem_write = mw;
   endtask

   task automatic drain();
      bus.in_valid = 0; bus.out_ready = 1; bus.flush = 0;
      tick();
   endtask

   initial begin
      idle();
      bus.out_ready = 1;

      // 1: reset state, then a simple imm-add
      repeat (2) tick();
      @(negedge clk);
      $display("txn reset: out_valid=%0d alu_op=%h", bus.out_valid, bus.alu_op);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
      chk("rst_alu_a",     bus.alu_a,          32'd0);
      chk("rst_reg_write", 32'(bus.out_reg_write), 32'd0);
      tick();
      rst = 0;
      offer(32'h100, 5'd1, 32'd5, 5'd0, 32'd0, 32'd7, 1'b1, 4'b0010, 5'd2, 1, 0, 0);
      tick();
      bus.in_valid = 0;
      @(negedge clk);
      $display("txn add: a=%h b=%h op=%h", bus.alu_a, bus.alu_b, bus.alu_op);
      chk("t1_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_a",     bus.alu_a,          32'd5);
      chk("t1_b",     bus.alu_b,          32'd7);
      chk("t1_op",    32'(bus.alu_op),    32'h2);

      // 2: EX/MEM beats MEM/WB; x0 never forwarded
      drain();
      offer(32'h104, 5'd3, 32'h11, 5'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 5'd5, 1, 0, 0);
      bus.exm_wen = 1; bus.exm_rd = 3; bus.exm_val = 32'hAA;
      bus.wb_wen  = 1; bus.wb_rd  = 3; bus.wb_val  = 32'hBB;
      tick();
      offer(32'h108, 5'd0, 32'h99, 5'd0, 32'd0, 32'd0, 1'b1, 4'b0000, 5'd5, 1, 0, 0);
      bus.exm_rd = 0; bus.exm_val = 32'h77; bus.wb_wen = 0;
      @(negedge clk);
      $display("txn fwd_prio: a=%h", bus.alu_a);
      chk("t2_prio", bus.alu_a, 32'hAA);
      tick();
      bus.in_valid = 0; bus.exm_wen = 0;
      @(negedge clk);
      $display("txn fwd_x0: a=%h", bus.alu_a);
      chk("t2_x0", bus.alu_a, 32'd0);

      // 3: load-use -> one bubble, then load data via EX/MEM
      drain();
      bus.out_ready = 0;
      offer(32'h200, 5'd1, 32'h100, 5'd0, 32'd0, 32'd8, 1'b1, 4'b0000, 5'd4, 1, 1, 0);
      tick();
      offer(32'h204, 5'd2, 32'd3, 5'd4, 32'hDEAD, 32'd0, 1'b0, 4'b0001, 5'd6, 1, 0, 0);
      bus.out_ready = 1;
      @(negedge clk);
      $display("txn lu_block: in_ready=%0d", bus.in_ready);
      chk("t3_blocked", 32'(bus.in_ready), 32'd0);
      tick();
      bus.exm_wen = 1; bus.exm_rd = 4; bus.exm_val = 32'h1234;
      @(negedge clk);
      $display("txn lu_bubble: out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);
      chk("t3_bubble", 32'(bus.out_valid), 32'd0);
      chk("t3_ready",  32'(bus.in_ready),  32'd1);
      tick();
      bus.in_valid = 0; bus.exm_wen = 0;
      @(negedge clk);
      $display("txn lu_dep: b=%h sd=%h", bus.alu_b, bus.out_store_data);
      chk("t3_valid", 32'(bus.out_valid), 32'd1);
      chk("t3_b",     bus.alu_b,          32'h1234);
      chk("t3_sd",    bus.out_store_data, 32'h1234);

      // 4: stall with a late MEM/WB result refreshing the held operand
      drain();
      bus.out_ready = 0;
      offer(32'h400, 5'd6, 32'h10, 5'd0, 32'd0, 32'd1, 1'b1, 4'b0101, 5'd7, 1, 0, 0);
      tick();
      bus.in_valid = 0;
      @(negedge clk);
      chk("t4_c1_a", bus.alu_a, 32'h10);
      tick();
      bus.wb_wen = 1; bus.wb_rd = 6; bus.wb_val = 32'h55;
      @(negedge clk);
      chk("t4_c2_a", bus.alu_a, 32'h10);
      tick();
      bus.wb_wen = 0;
      @(negedge clk);
      $display("txn stall_refresh: a=%h op=%h pc=%h", bus.alu_a, bus.alu_op, bus.out_pc);
      chk("t4_c3_a",  bus.alu_a,        32'h55);
      chk("t4_c3_op", 32'(bus.alu_op),  32'h5);
      chk("t4_c3_pc", bus.out_pc,       32'h400);
      chk("t4_c3_v",  32'(bus.out_valid), 32'd1);

      // 5: flush kills the held entry and the same-cycle incoming instruction
      drain();
      bus.out_ready = 0;
      offer(32'h500, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 4'b0111, 5'd9, 1, 0, 1);
      tick();
      offer(32'hDEAD, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 4'b1111, 5'd10, 1, 0, 0);
      bus.flush = 1;
      @(negedge clk);
      chk("t5_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
      @(negedge clk);
      $display("txn flush: out_valid=%0d rw=%0d mw=%0d", bus.out_valid, bus.out_reg_write, bus.out_mem_write);
      chk("t5_valid", 32'(bus.out_valid),     32'd0);
      chk("t5_rw",    32'(bus.out_reg_write), 32'd0);
      chk("t5_mw",    32'(bus.out_mem_write), 32'd0);
      tick();
      @(negedge clk);
      chk("t5_gone", 32'(bus.out_valid), 32'd0);

      // 6: back-to-back stream, full throughput
      for (int i = 0; i < 8; i++) begin
         offer(32'h600 + 32'(i * 4), 5'(10 + i), 32'(i), 5'd0, 32'd0, 32'(i),
               1'b1, 4'(2 * i + 1), 5'(20 + i), 1, 0, 0);
         tick();
         @(negedge clk);
         $display("txn stream %0d: valid=%0d op=%h", i, bus.out_valid, bus.alu_op);
         chk("t6_valid", 32'(bus.out_valid), 32'd1);
         chk("t6_op",    32'(bus.alu_op),    32'(2 * i + 1));
      end
      bus.in_valid = 0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
